muldiv_unit: RTL and testbench

- Iterative RV64M multiply/divide execution unit in the EX stage, directly downstream of the register file.
- Consumes the two register read operands plus the decoded funct3 and destination address.
- Produces a 64-bit result for writeback after a fixed multi-cycle latency.
- Uses a start/busy/valid handshake so the control unit stalls the pipeline while the unit is busy.

---
 rtl/muldiv_unit.sv | 120 ++++++++++++
 tb/tb_muldiv_unit.sv | 148 ++++++++++++++
 2 files changed

// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative RV64M multiply/divide unit with start/busy/valid handshake
module muldiv_unit #(
  parameter int XLEN   = 64,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              kill,
  input  logic [2:0]        funct3,
  input  logic [XLEN-1:0]   operand_a,
  input  logic [XLEN-1:0]   operand_b,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic              busy,
  output logic              result_valid,
  output logic [XLEN-1:0]   result,
  output logic [ADDR_W-1:0] result_rd_addr
);
  localparam int CW = $clog2(XLEN);
  localparam logic [XLEN-1:0] MIN_VAL = {1'b1, {(XLEN-1){1'b0}}};
  typedef enum logic [2:0] {IDLE, PREP, CALC, FIX, DONE} state_t;
  state_t state, state_nx;
  logic [2:0]        op;
  logic [XLEN-1:0]   a_q, b_q, opnd;
  logic [2*XLEN-1:0] acc;
  logic [CW-1:0]     cnt;
  logic [ADDR_W-1:0] rd_q;
  logic              sa, sb;
  logic              is_div, a_sgn, b_sgn, neg_a, neg_b, div_zero, ovf, special;
  logic [XLEN-1:0]   abs_a, abs_b, special_val, mul_res, div_res, fix_val, quo, rem;
  logic [XLEN:0]     mul_sum, rem_sh, diff;
  logic [2*XLEN-1:0] mul_nx, div_nx, prod;
  always_comb begin
    is_div      = op[2];
    a_sgn       = (op == 3'b001) | (op == 3'b010) | (op == 3'b100) | (op == 3'b110);
    b_sgn       = (op == 3'b001) | (op == 3'b100) | (op == 3'b110);
    neg_a       = a_sgn & a_q[XLEN-1];
    neg_b       = b_sgn & b_q[XLEN-1];
    abs_a       = neg_a ? -a_q : a_q;
    abs_b       = neg_b ? -b_q : b_q;
    div_zero    = is_div & (b_q == '0);
    ovf         = is_div & ~op[0] & (a_q == MIN_VAL) & (&b_q);
    special     = div_zero | ovf;
    special_val = div_zero ? (op[1] ? a_q : '1) : (op[1] ? '0 : a_q);
    // Shift-add: multiplier sits in the low half and is consumed LSB first
    mul_sum     = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, opnd} : '0);
    mul_nx      = {mul_sum, acc[XLEN-1:1]};
    // Restoring divide: partial remainder in the high half, quotient bits shift in low
    rem_sh      = acc[2*XLEN-1:XLEN-1];
    diff        = rem_sh - {1'b0, opnd};
    div_nx      = {diff[XLEN] ? rem_sh[XLEN-1:0] : diff[XLEN-1:0], acc[XLEN-2:0], ~diff[XLEN]};
    prod        = (sa ^ sb) ? -acc : acc;
    mul_res     = (op == 3'b000) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
    quo         = acc[XLEN-1:0];
    rem         = acc[2*XLEN-1:XLEN];
    div_res     = op[1] ? (sa ? -rem : rem) : ((sa ^ sb) ? -quo : quo);
    fix_val     = is_div ? div_res : mul_res;
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) state <= IDLE;
    else        state <= state_nx;
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    state_nx = (start & ~kill) ? PREP : IDLE;
      PREP:    state_nx = kill ? IDLE : special ? DONE : CALC;
      CALC:    state_nx = kill ? IDLE : (cnt == '0) ? FIX : CALC;
      FIX:     state_nx = kill ? IDLE : DONE;
      default: state_nx = IDLE;
    endcase
  end
  always_comb begin
    busy         = (state == PREP) | (state == CALC) | (state == FIX);
    result_valid = state == DONE;
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      op             <= '0;
      a_q            <= '0;
      b_q            <= '0;
      rd_q           <= '0;
      opnd           <= '0;
      acc            <= '0;
      cnt            <= '0;
      sa             <= 1'b0;
      sb             <= 1'b0;
      result         <= '0;
      result_rd_addr <= '0;
    end else begin
      case (state)
        IDLE: if (start & ~kill) begin
          op   <= funct3;
          a_q  <= operand_a;
          b_q  <= operand_b;
          rd_q <= rd_addr;
        end
        PREP: begin
          sa   <= neg_a;
          sb   <= neg_b;
          cnt  <= CW'(XLEN-1);
          opnd <= is_div ? abs_b : abs_a;
          acc  <= {{XLEN{1'b0}}, is_div ? abs_a : abs_b};
          if (!kill && special) begin
            result         <= special_val;
            result_rd_addr <= rd_q;
          end
        end
        CALC: begin
          acc <= is_div ? div_nx : mul_nx;
          cnt <= cnt - CW'(1);
        end
        FIX: if (!kill) begin
          result         <= fix_val;
          result_rd_addr <= rd_q;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: directed vectors plus kill/reset/busy-start sequences for muldiv_unit
module tb_muldiv_unit;
  logic        clk = 1'b0;
  logic        reset, start, kill;
  logic [2:0]  funct3;
  logic [63:0] operand_a, operand_b, result;
  logic [4:0]  rd_addr, result_rd_addr;
  logic        busy, result_valid;
  int          n_chk = 0, n_fail = 0;
  typedef struct {
    logic [2:0]  f;
    logic [63:0] a, b;
    logic [4:0]  rd;
    logic [63:0] exp;
    int          lat;
  } vec_t;
  vec_t tv[20];
  always #5 clk = ~clk;
  muldiv_unit #(.XLEN(64), .ADDR_W(5)) dut (
    .clk(clk), .reset(reset), .start(start), .kill(kill), .funct3(funct3),
    .operand_a(operand_a), .operand_b(operand_b), .rd_addr(rd_addr),
    .busy(busy), .result_valid(result_valid), .result(result), .result_rd_addr(result_rd_addr)
  );
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask
  task automatic run_op(input string nm, input vec_t v);
    int cyc, bad_busy;
    start = 1'b1; funct3 = v.f; operand_a = v.a; operand_b = v.b; rd_addr = v.rd;
    @(posedge clk); #1 start = 1'b0;
    cyc = 0; bad_busy = 0;
    do begin
      @(negedge clk);
      cyc++;
      if (!result_valid && busy !== 1'b1) bad_busy++;
    end while (!result_valid && cyc < 200);
    chk({nm, "_latency"}, 64'(cyc), 64'(v.lat));
    chk({nm, "_busy_window"}, 64'(bad_busy), 64'd0);
    chk({nm, "_busy_at_done"}, {63'd0, busy}, 64'd0);
    chk({nm, "_result"}, result, v.exp);
    chk({nm, "_rd"}, {59'd0, result_rd_addr}, {59'd0, v.rd});
    @(negedge clk);
    chk({nm, "_pulse_width"}, {63'd0, result_valid}, 64'd0);
  endtask
  initial begin
    int nv, vcyc;
    logic [63:0] got_r, last_r;
    logic [4:0]  got_rd;
    vec_t v;
    tv[0]  = '{3'b000, 64'd7, 64'hFFFF_FFFF_FFFF_FFFD, 5'd1, 64'hFFFF_FFFF_FFFF_FFEB, 67};
    tv[1]  = '{3'b011, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 5'd2, 64'hFFFF_FFFF_FFFF_FFFE, 67};
    tv[2]  = '{3'b001, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 5'd3, 64'd0, 67};
    tv[3]  = '{3'b010, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 5'd4, 64'hFFFF_FFFF_FFFF_FFFF, 67};
    tv[4]  = '{3'b010, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF, 5'd5, 64'd1, 67};
    tv[5]  = '{3'b000, 64'h0000_0001_0000_0001, 64'h0000_0001_0000_0001, 5'd6, 64'h0000_0002_0000_0001, 67};
    tv[6]  = '{3'b001, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 5'd7, 64'h4000_0000_0000_0000, 67};
    tv[7]  = '{3'b100, 64'hFFFF_FFFF_FFFF_FFEC, 64'd3, 5'd8, 64'hFFFF_FFFF_FFFF_FFFA, 67};
    tv[8]  = '{3'b110, 64'hFFFF_FFFF_FFFF_FFEC, 64'd3, 5'd9, 64'hFFFF_FFFF_FFFF_FFFE, 67};
    tv[9]  = '{3'b101, 64'd20, 64'd3, 5'd10, 64'd6, 67};
    tv[10] = '{3'b100, 64'd7, 64'hFFFF_FFFF_FFFF_FFFE, 5'd11, 64'hFFFF_FFFF_FFFF_FFFD, 67};
    tv[11] = '{3'b110, 64'd7, 64'hFFFF_FFFF_FFFF_FFFE, 5'd12, 64'd1, 67};
    tv[12] = '{3'b101, 64'hFFFF_FFFF_FFFF_FFFF, 64'h10, 5'd13, 64'h0FFF_FFFF_FFFF_FFFF, 67};
    tv[13] = '{3'b111, 64'hFFFF_FFFF_FFFF_FFFF, 64'h10, 5'd0, 64'hF, 67};
    tv[14] = '{3'b101, 64'd5, 64'd0, 5'd14, 64'hFFFF_FFFF_FFFF_FFFF, 2};
    tv[15] = '{3'b111, 64'd5, 64'd0, 5'd15, 64'd5, 2};
    tv[16] = '{3'b100, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 5'd16, 64'h8000_0000_0000_0000, 2};
    tv[17] = '{3'b110, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 5'd17, 64'd0, 2};
    tv[18] = '{3'b100, 64'hFFFF_FFFF_FFFF_FFFB, 64'd0, 5'd18, 64'hFFFF_FFFF_FFFF_FFFF, 2};
    tv[19] = '{3'b110, 64'hFFFF_FFFF_FFFF_FFFB, 64'd0, 5'd31, 64'hFFFF_FFFF_FFFF_FFFB, 2};
    reset = 1'b0; start = 1'b0; kill = 1'b0; funct3 = '0;
    operand_a = '0; operand_b = '0; rd_addr = '0;
    repeat (2) @(negedge clk);
    chk("reset_busy", {63'd0, busy}, 64'd0);
    chk("reset_valid", {63'd0, result_valid}, 64'd0);
    chk("reset_result", result, 64'd0);
    chk("reset_rd", {59'd0, result_rd_addr}, 64'd0);
    reset = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 20; i++) run_op($sformatf("vec%0d", i), tv[i]);
    last_r = tv[19].exp;
    // Kill a DIV at cycle 30, then launch a fresh DIVU in cycle 31
    start = 1'b1; funct3 = 3'b100; operand_a = 64'd1000; operand_b = 64'd7; rd_addr = 5'd9;
    @(posedge clk); #1 start = 1'b0;
    nv = 0;
    for (int c = 1; c <= 30; c++) begin
      @(negedge clk);
      if (result_valid) nv++;
    end
    kill = 1'b1;
    @(posedge clk); #1 kill = 1'b0;
    @(negedge clk);
    if (result_valid) nv++;
    chk("kill_no_valid", 64'(nv), 64'd0);
    chk("kill_idle", {63'd0, busy}, 64'd0);
    chk("kill_result_kept", result, last_r);
    v = '{3'b101, 64'd100, 64'd7, 5'd11, 64'd14, 67};
    run_op("after_kill", v);
    // Start while busy must be ignored
    start = 1'b1; funct3 = 3'b000; operand_a = 64'd3; operand_b = 64'd5; rd_addr = 5'd4;
    @(posedge clk); #1 start = 1'b0;
    nv = 0; vcyc = 0; got_r = '0; got_rd = '0;
    for (int c = 1; c <= 150; c++) begin
      @(negedge clk);
      if (c == 10) begin
        start = 1'b1; funct3 = 3'b011; operand_a = 64'd100; operand_b = 64'd100; rd_addr = 5'd20;
      end else start = 1'b0;
      if (result_valid) begin
        nv++;
        if (nv == 1) begin vcyc = c; got_r = result; got_rd = result_rd_addr; end
      end
    end
    chk("busy_start_count", 64'(nv), 64'd1);
    chk("busy_start_latency", 64'(vcyc), 64'd67);
    chk("busy_start_result", got_r, 64'd15);
    chk("busy_start_rd", {59'd0, got_rd}, 64'd4);
    // start and kill together in IDLE: not launched
    start = 1'b1; kill = 1'b1; funct3 = 3'b000; operand_a = 64'd9; operand_b = 64'd9; rd_addr = 5'd2;
    @(posedge clk); #1 begin start = 1'b0; kill = 1'b0; end
    @(negedge clk);
    chk("start_kill_busy", {63'd0, busy}, 64'd0);
    nv = 0;
    repeat (5) begin @(negedge clk); if (result_valid) nv++; end
    chk("start_kill_no_valid", 64'(nv), 64'd0);
    chk("start_kill_result", result, 64'd15);
    // Asynchronous reset in the middle of a MUL
    start = 1'b1; funct3 = 3'b000; operand_a = 64'd6; operand_b = 64'd7; rd_addr = 5'd3;
    @(posedge clk); #1 start = 1'b0;
    repeat (20) @(negedge clk);
    chk("mid_busy_before_reset", {63'd0, busy}, 64'd1);
    reset = 1'b0;
    #1;
    chk("mid_reset_busy", {63'd0, busy}, 64'd0);
    chk("mid_reset_valid", {63'd0, result_valid}, 64'd0);
    chk("mid_reset_result", result, 64'd0);
    chk("mid_reset_rd", {59'd0, result_rd_addr}, 64'd0);
    @(negedge clk);
    reset = 1'b1;
    nv = 0;
    repeat (100) begin @(negedge clk); if (result_valid) nv++; end
    chk("post_reset_no_valid", 64'(nv), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
